// File: rtl/fan_pwm_pkg.sv
// ---------------------------------------------------------------------------
// fan_pwm_pkg
// Shared definitions for the fan PWM controller:
//   - FSM state encoding
//   - default field widths
//   - slv_reg indices and bit positions of the software-visible fields
// ---------------------------------------------------------------------------
package fan_pwm_pkg;

    localparam int FAN_CW = 16;   // period counter / duty / step width
    localparam int FAN_PW = 8;    // prescaler width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RAMP = 2'd2
    } fan_pwm_state_t;

    // slv_reg indices
    localparam int REG_CTRL   = 3;  // {prescale[15:8], enable[0]}
    localparam int REG_PERIOD = 4;
    localparam int REG_DUTY   = 5;
    localparam int REG_STEP   = 6;
    localparam int REG_STATUS = 7;

    // ctrl register field positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PSC_LSB = 8;
    localparam int CTRL_PSC_MSB = 15;

endpackage

// File: rtl/fan_pwm_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler for the fan PWM. It emits one tick every prescale_sh+1 clocks.
// The prescale value is held in a shadow register that reloads only when
// 'load' is asserted.
// Ports:
//   axi_aclk    in  clock
//   axi_aresetn in  async active-low reset
//   clr         in  hold the counter at 0 and suppress tick
//   prescale    in  software prescale value (shadowed on load)
//   load        in  copy prescale into the shadow register
//   tick        out asserted in the clock where the count reaches prescale_sh
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int PW = 8
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic          clr,
    input  logic [PW-1:0] prescale,
    input  logic          load,
    output logic          tick
);

    logic [PW-1:0] r_psc_cnt;
    logic [PW-1:0] r_prescale_sh;

    assign tick = !clr && (r_psc_cnt == r_prescale_sh);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_psc_cnt     <= '0;
            r_prescale_sh <= '0;
        end else begin
            if (load) begin
                r_prescale_sh <= prescale;
            end
            if (clr || tick) begin
                r_psc_cnt <= '0;
            end else begin
                r_psc_cnt <= r_psc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fan_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// fan_pwm_ctrl
// Register-driven fan PWM generator with programmable period, duty and a
// soft-start / soft-change duty ramp.
// Ports:
//   axi_aclk    in  clock
//   axi_aresetn in  async active-low reset
//   enable      in  run request (level)
//   prescale    in  one tick every prescale+1 clocks
//   period      in  PWM period in ticks, minus 1
//   duty_target in  desired high ticks per period
//   ramp_step   in  maximum duty change per period (0 = jump immediately)
//   fan_pwm     out registered PWM output
//   duty_now    out duty currently applied
//   period_done out one-clock pulse in the first clock of each new period
//   ramp_busy   out high while the FSM is in RAMP
// ---------------------------------------------------------------------------
module fan_pwm_ctrl
    import fan_pwm_pkg::*;
#(
    parameter int CW = FAN_CW,
    parameter int PW = FAN_PW
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic          enable,
    input  logic [PW-1:0] prescale,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] duty_target,
    input  logic [CW-1:0] ramp_step,
    output logic          fan_pwm,
    output logic [CW-1:0] duty_now,
    output logic          period_done,
    output logic          ramp_busy
);

    fan_pwm_state_t r_state;
    fan_pwm_state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_period_sh;
    logic [CW-1:0] r_duty;
    logic          r_pwm;
    logic          r_done;

    logic          w_clr;
    logic          w_load;
    logic          w_tick;
    logic          w_wrap;
    logic [CW:0]   w_up;
    logic [CW:0]   w_dn;
    logic [CW-1:0] w_duty_ramp;
    logic [CW-1:0] w_duty_entry;
    logic [CW-1:0] w_duty_nxt;

    // Counters are frozen in IDLE and on the edge that leaves any run state,
    // so a disable coinciding with a wrap produces neither a wrap nor a pulse.
    assign w_clr  = (r_state == IDLE) || !enable;
    assign w_wrap = w_tick && (r_cnt == r_period_sh);
    // Shadows track software continuously while idle, otherwise only at wrap.
    assign w_load = (r_state == IDLE) || w_wrap;

    tick_gen #(
        .PW(PW)
    ) u_tick_gen (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .clr        (w_clr),
        .prescale   (prescale),
        .load       (w_load),
        .tick       (w_tick)
    );

    // Ramp arithmetic at CW+1 bits: the add cannot wrap, and the subtract
    // borrow bit flags an undershoot below zero.
    assign w_up = {1'b0, r_duty} + {1'b0, ramp_step};
    assign w_dn = {1'b0, r_duty} - {1'b0, ramp_step};

    always_comb begin
        w_duty_ramp = r_duty;
        if (ramp_step == '0) begin
            w_duty_ramp = duty_target;
        end else if (r_duty < duty_target) begin
            w_duty_ramp = (w_up >= {1'b0, duty_target}) ? duty_target : w_up[CW-1:0];
        end else if (r_duty > duty_target) begin
            w_duty_ramp = (w_dn[CW] || (w_dn[CW-1:0] <= duty_target)) ? duty_target
                                                                     : w_dn[CW-1:0];
        end
    end

    assign w_duty_entry = (ramp_step == '0) ? duty_target : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        case (r_state)
            IDLE: begin
                w_duty_nxt = '0;
                if (enable) begin
                    w_duty_nxt  = w_duty_entry;
                    w_state_nxt = (w_duty_entry == duty_target) ? RUN : RAMP;
                end
            end
            RUN, RAMP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_duty_nxt  = '0;
                end else if (w_wrap) begin
                    w_duty_nxt  = w_duty_ramp;
                    w_state_nxt = (w_duty_ramp == duty_target) ? RUN : RAMP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_duty_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty      <= '0;
            r_pwm       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            if (w_load) begin
                r_period_sh <= period;
            end
            if (w_clr || w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_pwm  <= !w_clr && (r_cnt < r_duty);
            r_done <= w_wrap;
        end
    end

    assign fan_pwm     = r_pwm;
    assign duty_now    = r_duty;
    assign period_done = r_done;
    assign ramp_busy   = (r_state == RAMP);

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fan_pwm_ctrl
// Scoreboard bench for fan_pwm_ctrl. The stimulus process runs each
// configuration on a timeline computed from the period arithmetic and pushes
// the expected entry/wrap observations; the monitor pops one on every
// period_done (and on entry) and compares duty, busy, period length and
// high time of the period just finished.
// ---------------------------------------------------------------------------
module tb_fan_pwm_ctrl;

    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] psc = '0;
    logic [CW-1:0] per = '0;
    logic [CW-1:0] tgt = '0;
    logic [CW-1:0] stp = '0;
    logic          fan_pwm;
    logic [CW-1:0] duty_now;
    logic          period_done;
    logic          ramp_busy;

    fan_pwm_ctrl #(
        .CW(CW),
        .PW(PW)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .enable     (en),
        .prescale   (psc),
        .period     (per),
        .duty_target(tgt),
        .ramp_step  (stp),
        .fan_pwm    (fan_pwm),
        .duty_now   (duty_now),
        .period_done(period_done),
        .ramp_busy  (ramp_busy)
    );

    always #5 clk = ~clk;

    // kind 0 = entry observation, 1 = wrap observation
    typedef struct {
        int kind;
        int duty;
        int busy;
        int len;
        int hi;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // monitor state
    int   m_hcnt = 0;
    int   m_len = 0;
    int   m_skip = 0;
    bit   m_prev_en = 1'b0;
    bit   m_ent_p = 1'b0;
    bit   m_dis_p = 1'b0;
    exp_t m_e;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Duty after one wrap: step toward target, never past it.
    function automatic int move(input int d, input int t, input int s);
        if (s == 0) return t;
        if (d < t) return (d + s > t) ? t : d + s;
        if (d > t) return (d - s < t) ? t : d - s;
        return d;
    endfunction

    // One enable session. ck/cm: period index and clock offset of a single
    // mid-period reprogramming (ck<0: none, cm<0: random offset).
    // drop: clock offset in the final period to drop enable
    // (-1 random inside the period, -2 on the wrap edge).
    task automatic do_run(input int P, input int S, input int T, input int st,
                          input int nper, input int ck, input int cm,
                          input int nP, input int nS, input int nT, input int nst,
                          input int drop);
        int d, dn, L, hi, m, r, cP, cS, cT, cst, clamp;
        per = CW'(P); psc = PW'(S); tgt = CW'(T); stp = CW'(st);
        clks(2);
        d = (st == 0) ? T : 0;
        q.push_back('{0, d, int'(d != T), 0, 0});
        en = 1'b1;
        clks(1);
        cP = P; cS = S; cT = T; cst = st;
        for (int k = 0; k < nper; k++) begin
            L     = (cP + 1) * (cS + 1);
            clamp = (d < cP + 1) ? d : cP + 1;
            hi    = clamp * (cS + 1);
            m     = 0;
            if (k == ck) begin
                m   = (cm < 0) ? int'($urandom_range(0, L - 1)) : cm;
                cP  = nP; cS = nS; cT = nT; cst = nst;
            end
            dn = move(d, cT, cst);
            q.push_back('{1, dn, int'(dn != cT), L, hi});
            if (k == ck) begin
                clks(m);
                per = CW'(nP); psc = PW'(nS); tgt = CW'(nT); stp = CW'(nst);
                clks(L - m);
            end else begin
                clks(L);
            end
            d = dn;
        end
        L = (cP + 1) * (cS + 1);
        if (drop == -2)      r = L - 1;
        else if (drop == -1) r = int'($urandom_range(0, L - 2));
        else                 r = drop;
        clks(r);
        en = 1'b0;
        clks(3);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                m_prev_en = en;
            end else begin
                if (m_skip > 0) begin
                    m_skip--;
                end else begin
                    m_len++;
                    if (fan_pwm) m_hcnt++;
                end
                if (m_ent_p) begin
                    m_ent_p = 1'b0;
                    chk("entry_expected", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        m_e = q.pop_front();
                        chk("entry_kind", m_e.kind, 0);
                        chk("entry_duty", int'(duty_now), m_e.duty);
                        chk("entry_busy", int'(ramp_busy), m_e.busy);
                        chk("entry_pwm", int'(fan_pwm), 0);
                        chk("entry_done", int'(period_done), 0);
                    end
                end else if (m_dis_p) begin
                    m_dis_p = 1'b0;
                    chk("dis_pwm", int'(fan_pwm), 0);
                    chk("dis_duty", int'(duty_now), 0);
                    chk("dis_busy", int'(ramp_busy), 0);
                    chk("dis_done", int'(period_done), 0);
                end else if (period_done) begin
                    chk("done_expected", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        m_e = q.pop_front();
                        chk("wrap_kind", m_e.kind, 1);
                        chk("wrap_duty", int'(duty_now), m_e.duty);
                        chk("wrap_busy", int'(ramp_busy), m_e.busy);
                        chk("period_len", m_len, m_e.len);
                        chk("high_time", m_hcnt, m_e.hi);
                    end
                    m_hcnt = 0;
                    m_len  = 0;
                end
                if (en && !m_prev_en) begin
                    m_hcnt  = 0;
                    m_len   = 0;
                    m_skip  = 1;
                    m_ent_p = 1'b1;
                end
                if (!en && m_prev_en) m_dis_p = 1'b1;
                m_prev_en = en;
            end
        end
    end

    initial begin
        int P, S, T, st, np, ck, nP, nS, nT, nst, dr;
        clks(3);
        chk("rst_pwm", int'(fan_pwm), 0);
        chk("rst_duty", int'(duty_now), 0);
        chk("rst_done", int'(period_done), 0);
        chk("rst_busy", int'(ramp_busy), 0);
        rst_n = 1'b1;
        clks(2);
        mon_en = 1'b1;

        //     P  S  T  st np  ck cm  nP nS nT nst drop
        do_run(9, 0, 5, 0, 4, -1, 0,  0, 0, 0, 0,  3);   // jump, drop at cnt=3
        do_run(9, 0, 8, 3, 5, -1, 0,  0, 0, 0, 0, -2);   // soft start, drop on wrap
        do_run(4, 3, 2, 0, 3, -1, 0,  0, 0, 0, 0, -1);   // prescale 8/12
        do_run(4, 3, 7, 0, 2, -1, 0,  0, 0, 0, 0, -1);   // clamp high
        do_run(4, 3, 0, 0, 2, -1, 0,  0, 0, 0, 0, -1);   // clamp low
        do_run(9, 0, 5, 0, 3,  1, 4, 19, 0, 5, 0, -1);   // period 9->19 at cnt=4
        do_run(9, 0, 5, 0, 3,  1, 1,  9, 0, 2, 0, -2);   // duty 5->2 at cnt=1
        do_run(9, 0, 8, 0, 5,  1, 3,  9, 0, 1, 5, -1);   // ramp down 8,3,1,1

        for (int i = 0; i < 20; i++) begin
            P   = int'($urandom_range(1, 15));
            S   = int'($urandom_range(0, 3));
            T   = int'($urandom_range(0, 20));
            st  = int'($urandom_range(0, 7));
            np  = int'($urandom_range(3, 6));
            ck  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, np - 1)) : -1;
            nP  = int'($urandom_range(1, 15));
            nS  = int'($urandom_range(0, 3));
            nT  = int'($urandom_range(0, 20));
            nst = int'($urandom_range(0, 7));
            dr  = ($urandom_range(0, 1) == 1) ? -2 : -1;
            do_run(P, S, T, st, np, ck, -1, nP, nS, nT, nst, dr);
        end

        // asynchronous reset in the middle of a high phase
        mon_en = 1'b0;
        per = CW'(9); psc = '0; tgt = CW'(5); stp = '0;
        clks(2);
        en = 1'b1;
        clks(4);
        chk("pre_reset_pwm", int'(fan_pwm), 1);
        chk("pre_reset_duty", int'(duty_now), 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_pwm", int'(fan_pwm), 0);
        chk("areset_duty", int'(duty_now), 0);
        chk("areset_done", int'(period_done), 0);
        chk("areset_busy", int'(ramp_busy), 0);
        en = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(2);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
